// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store unit with lane alignment, load extension, misalign and bus-timeout flags
module mem_access_unit #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] address,
    input  logic [XLEN-1:0] write_data,
    input  logic [1:0]      inst_size,
    input  logic            load_unsigned,
    input  logic            mem_read,
    input  logic            mem_write,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] read_data,
    output logic            misalign_exc,
    output logic            bus_err,
    output logic            stall,
    output logic            mreq,
    output logic            write,
    output logic [XLEN-1:0] addr,
    output logic [1:0]      access_size,
    output logic [3:0]      byte_en,
    output logic [XLEN-1:0] wr_data,
    input  logic            mem_ack,
    input  logic [XLEN-1:0] rd_data
);
    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       off;
    logic             lu, ld;
    logic             is_op, bad;
    logic [3:0]       be_n;
    logic [XLEN-1:0]  wd_n, ext;
    logic [15:0]      lane;
    always_comb begin
        is_op = mem_read | mem_write;
        bad   = inst_size == 2'b11 || (mem_read && mem_write) ||
                (inst_size == 2'b01 && address[0]) ||
                (inst_size == 2'b10 && address[1:0] != 2'b00);
        be_n  = inst_size == 2'b00 ? 4'b0001 << address[1:0] :
                inst_size == 2'b01 ? 4'b0011 << address[1:0] : 4'b1111;
        wd_n  = inst_size == 2'b00 ? {4{write_data[7:0]}} :
                inst_size == 2'b01 ? {2{write_data[15:0]}} : write_data;
        lane  = 16'(rd_data >> {off, 3'b000});
        ext   = access_size == 2'b00 ? {{(XLEN-8){~lu & lane[7]}}, lane[7:0]} :
                access_size == 2'b01 ? {{(XLEN-16){~lu & lane[15]}}, lane} : rd_data;
    end
    assign stall = (in_valid && !in_ready) || (out_valid && !out_ready);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            in_ready     <= 1'b1;
            out_valid    <= 1'b0;
            mreq         <= 1'b0;
            write        <= 1'b0;
            byte_en      <= '0;
            addr         <= '0;
            wr_data      <= '0;
            access_size  <= '0;
            read_data    <= '0;
            misalign_exc <= 1'b0;
            bus_err      <= 1'b0;
            cnt          <= '0;
            off          <= '0;
            lu           <= 1'b0;
            ld           <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid && in_ready) begin
                    in_ready <= 1'b0;
                    if (!is_op || bad) begin
                        // Non-memory ops and illegal accesses answer directly without touching the bus
                        state        <= RESP;
                        out_valid    <= 1'b1;
                        misalign_exc <= is_op;
                        read_data    <= '0;
                    end else begin
                        state       <= REQ;
                        mreq        <= 1'b1;
                        write       <= mem_write;
                        addr        <= {address[XLEN-1:2], 2'b00};
                        access_size <= inst_size;
                        byte_en     <= be_n;
                        wr_data     <= wd_n;
                        off         <= address[1:0];
                        lu          <= load_unsigned;
                        ld          <= mem_read;
                        cnt         <= '0;
                    end
                end
                REQ: if (mem_ack) begin
                    mreq      <= 1'b0;
                    write     <= 1'b0;
                    read_data <= ld ? ext : '0;
                    out_valid <= 1'b1;
                    state     <= RESP;
                end else if (TIMEOUT != 0 && cnt == CNT_W'(TIMEOUT - 1)) begin
                    mreq      <= 1'b0;
                    write     <= 1'b0;
                    bus_err   <= 1'b1;
                    read_data <= '0;
                    out_valid <= 1'b1;
                    state     <= RESP;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                RESP: if (out_ready) begin
                    state        <= IDLE;
                    out_valid    <= 1'b0;
                    misalign_exc <= 1'b0;
                    bus_err      <= 1'b0;
                    read_data    <= '0;
                    in_ready     <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: scoreboard bench for the load/store unit, one task per scenario
module tb_mem_access_unit;
    logic        clk = 0, rst_n = 0;
    logic        in_valid = 0, in_ready, load_unsigned = 0, mem_read = 0, mem_write = 0;
    logic [31:0] address = 0, write_data = 0, read_data, addr, wr_data, rd_data = 0;
    logic [1:0]  inst_size = 0, access_size;
    logic        out_valid, out_ready = 0, misalign_exc, bus_err, stall, mreq, write, mem_ack = 0;
    logic [3:0]  byte_en;

    typedef struct packed {logic [31:0] rd; logic mis; logic berr;} exp_t;
    exp_t sb[$];
    exp_t e;
    int checks = 0, failures = 0;
    int lat, n;
    logic [3:0]  be;
    logic [31:0] wdo;
    logic        wro, to;

    mem_access_unit #(.XLEN(32), .TIMEOUT(16), .CNT_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .address(address), .write_data(write_data), .inst_size(inst_size),
        .load_unsigned(load_unsigned), .mem_read(mem_read), .mem_write(mem_write),
        .out_valid(out_valid), .out_ready(out_ready), .read_data(read_data),
        .misalign_exc(misalign_exc), .bus_err(bus_err), .stall(stall), .mreq(mreq),
        .write(write), .addr(addr), .access_size(access_size), .byte_en(byte_en),
        .wr_data(wr_data), .mem_ack(mem_ack), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    function automatic logic [31:0] model(input logic [31:0] a, input logic [1:0] sz,
                                          input logic u, input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        b = d[8*a[1:0] +: 8];
        h = d[8*a[1:0] +: 16];
        if (sz == 2'b00) return u ? {24'h0, b} : {{24{b[7]}}, b};
        if (sz == 2'b01) return u ? {16'h0, h} : {{16{h[15]}}, h};
        return d;
    endfunction

    // Drives one accepted op and plays memory; returns at the first cycle out_valid is seen
    task automatic do_access(input logic [31:0] a, wd, input logic [1:0] sz, input logic u, rd, wr,
                             input int ack_after, input logic [31:0] rdat,
                             output int l, output int cnt, output logic [3:0] be_o,
                             output logic [31:0] wd_o, output logic wr_o, output logic tmo);
        @(negedge clk);
        address = a; write_data = wd; inst_size = sz; load_unsigned = u;
        mem_read = rd; mem_write = wr; in_valid = 1;
        @(posedge clk); #1;
        in_valid = 0; l = 0; cnt = 0; be_o = 0; wd_o = 0; wr_o = 0; tmo = 1;
        for (int c = 0; c < 100; c++) begin
            if (out_valid) begin l = c; tmo = 0; break; end
            mem_ack = 0;
            if (mreq) begin
                cnt++; be_o = byte_en; wd_o = wr_data; wr_o = write;
                if (cnt == ack_after) begin mem_ack = 1; rd_data = rdat; end
            end
            @(posedge clk); #1;
        end
        mem_ack = 0;
    endtask

    task automatic complete();
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({mreq, write, byte_en, addr, wr_data, access_size, read_data, misalign_exc, bus_err, out_valid, stall} !== '0) begin
            failures++; $display("FAIL reset_outputs got mreq=%b be=%b addr=%h rd=%h ov=%b", mreq, byte_en, addr, read_data, out_valid);
        end
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        @(negedge clk); rst_n = 1;
    endtask

    task automatic test_lw();
        sb.push_back('{32'hDEADBEEF, 1'b0, 1'b0});
        do_access(32'h100, 0, 2'b10, 0, 1, 0, 3, 32'hDEADBEEF, lat, n, be, wdo, wro, to);
        e = sb.pop_front();
        checks++; if (to !== 1'b0) begin failures++; $display("FAIL lw_timeout no out_valid"); end
        checks++; if (n != 3) begin failures++; $display("FAIL lw_mreq_cycles got=%0d exp=3", n); end
        checks++; if (be !== 4'b1111) begin failures++; $display("FAIL lw_byte_en got=%b exp=1111", be); end
        checks++; if (lat != 3) begin failures++; $display("FAIL lw_latency got=%0d exp=3", lat); end
        checks++; if (addr !== 32'h100) begin failures++; $display("FAIL lw_addr got=%h exp=00000100", addr); end
        checks++;
        if ({read_data, misalign_exc, bus_err} !== {e.rd, e.mis, e.berr}) begin
            failures++; $display("FAIL lw_result got=%h/%b/%b exp=%h/%b/%b", read_data, misalign_exc, bus_err, e.rd, e.mis, e.berr);
        end
        complete();
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL lw_return_idle got ir=%b ov=%b exp 1/0", in_ready, out_valid); end
    endtask

    task automatic test_lb();
        for (int k = 0; k < 2; k++) begin
            sb.push_back('{k ? 32'h00000080 : 32'hFFFFFF80, 1'b0, 1'b0});
            do_access(32'h103, 0, 2'b00, k[0], 1, 0, 1, 32'h80000000, lat, n, be, wdo, wro, to);
            e = sb.pop_front();
            checks++; if (be !== 4'b1000) begin failures++; $display("FAIL lb_byte_en got=%b exp=1000", be); end
            checks++; if (lat != 1 || to !== 1'b0) begin failures++; $display("FAIL lb_min_latency got=%0d exp=1", lat); end
            checks++; if (addr !== 32'h100) begin failures++; $display("FAIL lb_addr got=%h exp=00000100", addr); end
            checks++;
            if ({read_data, misalign_exc, bus_err} !== {e.rd, e.mis, e.berr}) begin
                failures++; $display("FAIL lb_result u=%0d got=%h exp=%h", k, read_data, e.rd);
            end
            complete();
        end
    endtask

    task automatic test_sh();
        sb.push_back('{32'h0, 1'b0, 1'b0});
        do_access(32'h102, 32'h1234ABCD, 2'b01, 0, 0, 1, 2, 32'hFFFFFFFF, lat, n, be, wdo, wro, to);
        e = sb.pop_front();
        checks++; if (be !== 4'b1100) begin failures++; $display("FAIL sh_byte_en got=%b exp=1100", be); end
        checks++; if (wdo !== 32'hABCDABCD) begin failures++; $display("FAIL sh_wr_data got=%h exp=abcdabcd", wdo); end
        checks++; if (wro !== 1'b1) begin failures++; $display("FAIL sh_write got=%b exp=1", wro); end
        checks++; if (access_size !== 2'b01) begin failures++; $display("FAIL sh_access_size got=%b exp=01", access_size); end
        checks++;
        if ({read_data, misalign_exc, bus_err} !== {e.rd, e.mis, e.berr} || to !== 1'b0) begin
            failures++; $display("FAIL sh_result got=%h/%b/%b exp=%h/%b/%b", read_data, misalign_exc, bus_err, e.rd, e.mis, e.berr);
        end
        complete();
    endtask

    task automatic test_misalign();
        // LW @101, LH @101, size 11, read+write, then a plain non-memory op
        logic [31:0] as [5] = '{32'h101, 32'h101, 32'h100, 32'h100, 32'h100};
        logic [1:0]  ss [5] = '{2'b10, 2'b01, 2'b11, 2'b10, 2'b10};
        logic        rs [5] = '{1, 1, 1, 1, 0};
        logic        ws [5] = '{0, 0, 0, 1, 0};
        for (int k = 0; k < 5; k++) begin
            sb.push_back('{32'h0, k != 4, 1'b0});
            do_access(as[k], 32'h55, ss[k], 0, rs[k], ws[k], 1, 32'hFFFFFFFF, lat, n, be, wdo, wro, to);
            e = sb.pop_front();
            checks++; if (n != 0 || lat != 0 || to !== 1'b0) begin failures++; $display("FAIL misalign_path k=%0d mreq_cycles=%0d lat=%0d exp 0/0", k, n, lat); end
            checks++;
            if ({read_data, misalign_exc, bus_err} !== {e.rd, e.mis, e.berr}) begin
                failures++; $display("FAIL misalign_result k=%0d got=%h/%b/%b exp=%h/%b/%b", k, read_data, misalign_exc, bus_err, e.rd, e.mis, e.berr);
            end
            complete();
            checks++; if (misalign_exc !== 1'b0) begin failures++; $display("FAIL misalign_clear k=%0d got=%b exp=0", k, misalign_exc); end
        end
    endtask

    task automatic test_timeout();
        sb.push_back('{32'h0, 1'b0, 1'b1});
        do_access(32'h200, 0, 2'b10, 0, 1, 0, 0, 32'h0, lat, n, be, wdo, wro, to);
        e = sb.pop_front();
        checks++; if (n != 16) begin failures++; $display("FAIL timeout_mreq_cycles got=%0d exp=16", n); end
        checks++; if (mreq !== 1'b0) begin failures++; $display("FAIL timeout_mreq_drop got=%b exp=0", mreq); end
        checks++;
        if ({read_data, misalign_exc, bus_err} !== {e.rd, e.mis, e.berr} || to !== 1'b0) begin
            failures++; $display("FAIL timeout_result got=%h/%b/%b exp=%h/%b/%b", read_data, misalign_exc, bus_err, e.rd, e.mis, e.berr);
        end
        complete();
        // ack on the last allowed cycle completes normally
        sb.push_back('{32'hCAFEF00D, 1'b0, 1'b0});
        do_access(32'h204, 0, 2'b10, 0, 1, 0, 16, 32'hCAFEF00D, lat, n, be, wdo, wro, to);
        e = sb.pop_front();
        checks++;
        if ({read_data, misalign_exc, bus_err} !== {e.rd, e.mis, e.berr} || n != 16) begin
            failures++; $display("FAIL ack_at_expiry got=%h/%b/%b n=%0d exp=%h/%b/%b n=16", read_data, misalign_exc, bus_err, n, e.rd, e.mis, e.berr);
        end
        complete();
    endtask

    task automatic test_backpressure();
        sb.push_back('{32'hFFFF8001, 1'b0, 1'b0});
        do_access(32'h302, 0, 2'b01, 0, 1, 0, 2, 32'h80010000, lat, n, be, wdo, wro, to);
        e = sb.pop_front();
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (out_valid !== 1'b1 || read_data !== e.rd || stall !== 1'b1) begin
                failures++; $display("FAIL backpressure cyc=%0d got ov=%b rd=%h stall=%b exp 1/%h/1", k, out_valid, read_data, stall, e.rd);
            end
            @(posedge clk); #1;
        end
        complete();
        checks++; if (out_valid !== 1'b0 || stall !== 1'b0) begin failures++; $display("FAIL backpressure_release got ov=%b stall=%b exp 0/0", out_valid, stall); end
    endtask

    task automatic test_back_to_back();
        sb.push_back('{32'h00000011, 1'b0, 1'b0});
        do_access(32'h400, 0, 2'b00, 1, 1, 0, 1, 32'hAABBCC11, lat, n, be, wdo, wro, to);
        e = sb.pop_front();
        in_valid = 1; #1;
        checks++; if (in_ready !== 1'b0 || stall !== 1'b1) begin failures++; $display("FAIL b2b_busy got ir=%b stall=%b exp 0/1", in_ready, stall); end
        checks++; if (read_data !== e.rd) begin failures++; $display("FAIL b2b_first got=%h exp=%h", read_data, e.rd); end
        in_valid = 0;
        complete();
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_random();
        logic [31:0] a, d;
        logic [1:0]  sz;
        logic        u;
        for (int k = 0; k < 12; k++) begin
            sz = 2'($urandom_range(0, 2));
            u  = 1'($urandom_range(0, 1));
            a  = $urandom & (sz == 2'b10 ? 32'hFFFFFFFC : sz == 2'b01 ? 32'hFFFFFFFE : 32'hFFFFFFFF);
            d  = $urandom;
            sb.push_back('{model(a, sz, u, d), 1'b0, 1'b0});
            do_access(a, 0, sz, u, 1, 0, $urandom_range(1, 4), d, lat, n, be, wdo, wro, to);
            e = sb.pop_front();
            checks++;
            if ({read_data, misalign_exc, bus_err} !== {e.rd, e.mis, e.berr} || to !== 1'b0) begin
                failures++; $display("FAIL random_load k=%0d a=%h sz=%0d u=%b got=%h exp=%h", k, a, sz, u, read_data, e.rd);
            end
            complete();
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        address = 32'h500; inst_size = 2'b10; mem_read = 1; mem_write = 0; in_valid = 1;
        @(posedge clk); #1;
        in_valid = 0;
        @(posedge clk); #1;
        checks++; if (mreq !== 1'b1) begin failures++; $display("FAIL reset_mid_req got mreq=%b exp=1", mreq); end
        rst_n = 0; #1;
        checks++;
        if ({mreq, write, byte_en, addr, wr_data, access_size, read_data, misalign_exc, bus_err, out_valid} !== '0 || in_ready !== 1'b1) begin
            failures++; $display("FAIL reset_mid_outputs got mreq=%b addr=%h be=%b ir=%b", mreq, addr, byte_en, in_ready);
        end
        @(negedge clk); rst_n = 1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0 || mreq !== 1'b0) begin failures++; $display("FAIL reset_mid_dropped got ov=%b mreq=%b exp 0/0", out_valid, mreq); end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_lb();
        test_sh();
        test_misalign();
        test_timeout();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
